// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response channel.
// master = fetch side (drives requests), slave = memory side.
// Ports: imem_req_valid/addr (master->slave), imem_req_ready,
//        imem_resp_valid, imem_resp_data (slave->master).
interface fetch_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V IF stage with IF/ID register, single-outstanding imem.
// Ports: clk, reset (sync, active-high); StallF/StallD/FlushD from hazard
//   unit; PCSrcE/PCTargetE redirect from Execute; imem (fetch_stage_if
//   master); InstrD/PCD/PCPlus4D/ValidD to Decode.
// Optional: define FETCH_PERF_EN to add perf_fetch_cnt/perf_stall_cnt.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          StallF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          PCSrcE,
    input  logic [31:0]   PCTargetE,
    fetch_stage_if.master imem,
    output logic [31:0]   InstrD,
    output logic [31:0]   PCD,
    output logic [31:0]   PCPlus4D,
    output logic          ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DISCARD,
        S_HOLD
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t BUBBLE = '{
        instr: NOP_INSTR,
        pc:    32'h0,
        pc4:   32'h0,
        valid: 1'b0
    };

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] infl_q;
    logic [31:0] infl_plus4;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc_q;
    if_id_t      ifid_q, ifid_d;

    logic        accept;
    logic        deliver_mem;
    logic        deliver_buf;
    logic        capture;

    assign infl_plus4 = infl_q + 32'd4;

    // Request decoded straight from state so accept has no comb loop.
    assign imem.imem_req_valid = (state_q == S_REQ) && !StallF && !reset;
    assign imem.imem_req_addr  = pcf_q;
    assign accept = imem.imem_req_valid && imem.imem_req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        deliver_mem = 1'b0;
        deliver_buf = 1'b0;
        capture     = 1'b0;
        unique case (state_q)
            S_REQ: begin
                // Redirect racing an acceptance leaves a stale response.
                if (accept) state_d = PCSrcE ? S_DISCARD : S_WAIT;
                if (PCSrcE) pcf_d = PCTargetE;
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = imem.imem_resp_valid ? S_REQ : S_DISCARD;
                end else if (imem.imem_resp_valid) begin
                    pcf_d = infl_plus4;
                    if (StallD) begin
                        capture = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        deliver_mem = 1'b1;
                        state_d     = S_REQ;
                    end
                end
            end
            S_DISCARD: begin
                if (PCSrcE) pcf_d = PCTargetE;
                if (imem.imem_resp_valid) state_d = S_REQ;
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    pcf_d   = PCTargetE;
                    state_d = S_REQ;
                end else if (!StallD) begin
                    deliver_buf = 1'b1;
                    state_d     = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // A delivery suppressed by FlushD is simply lost.
    always_comb begin
        ifid_d = ifid_q;
        if (FlushD) begin
            ifid_d = BUBBLE;
        end else if (!StallD) begin
            if (deliver_mem) begin
                ifid_d = '{
                    instr: imem.imem_resp_data,
                    pc:    infl_q,
                    pc4:   infl_plus4,
                    valid: 1'b1
                };
            end else if (deliver_buf) begin
                ifid_d = '{
                    instr: hold_instr_q,
                    pc:    hold_pc_q,
                    pc4:   hold_pc_q + 32'd4,
                    valid: 1'b1
                };
            end else begin
                ifid_d = BUBBLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q        <= RESET_PC;
            infl_q       <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= 32'h0;
            ifid_q       <= BUBBLE;
        end else begin
            pcf_q  <= pcf_d;
            ifid_q <= ifid_d;
            if (accept) infl_q <= pcf_q;
            if (capture) begin
                hold_instr_q <= imem.imem_resp_data;
                hold_pc_q    <= infl_q;
            end
        end
    end

    assign InstrD   = ifid_q.instr;
    assign PCD      = ifid_q.pc;
    assign PCPlus4D = ifid_q.pc4;
    assign ValidD   = ifid_q.valid;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        fetch_inc;
    logic        stall_inc;

    assign fetch_inc = (deliver_mem || deliver_buf) && !FlushD;
    assign stall_inc = StallD || (state_q == S_WAIT)
                    || (state_q == S_DISCARD);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            stall_cnt_q <= 32'h0;
        end else begin
            if (fetch_inc) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_inc) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a transaction-level
// reference model and a tagged-word instruction memory.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem      (imem),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory knobs
    int   mem_lat = 1;
    logic stray   = 1'b0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_live;
    logic [31:0] m_oaddr;
    logic        m_rdy;
    logic [31:0] m_raddr;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;
    int          cycn;
    int          n_acc;
    int          n_10c;
    int          acc_cy [3];
    logic [31:0] acc_ad [3];

    task automatic m_bubble();
        m_instr = 32'h13;
        m_pcd   = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // Model + memory, both sampling the pre-edge values
    initial begin
        int          rem;
        logic [31:0] maddr;
        logic        acc_d;
        logic        acc_m;
        logic        dlv;
        logic [31:0] a0;
        rem   = 0;
        maddr = 32'h0;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = 32'h0;
        m_pc = 32'h0; m_out = 1'b0; m_live = 1'b0; m_oaddr = 32'h0;
        m_rdy = 1'b0; m_raddr = 32'h0; m_fetch = 32'h0; m_stall = 32'h0;
        cycn = 0; n_acc = 0; n_10c = 0;
        m_bubble();
        forever begin
            @(posedge clk);
            acc_d = imem.imem_req_valid && imem.imem_req_ready;
            acc_m = !reset && !m_out && !m_rdy && !StallF
                 && imem.imem_req_ready;
            if (reset) begin
                m_pc = 32'h0; m_out = 1'b0; m_rdy = 1'b0;
                m_fetch = 32'h0; m_stall = 32'h0; cycn = 0;
                m_bubble();
            end else begin
                cycn++;
                if (acc_d) begin
                    if (n_acc < 3) begin
                        acc_cy[n_acc] = cycn;
                        acc_ad[n_acc] = imem.imem_req_addr;
                    end
                    n_acc++;
                    if (imem.imem_req_addr == 32'h10C) n_10c++;
                end
                if (StallD || m_out) m_stall = m_stall + 32'd1;
                a0  = m_pc;
                dlv = 1'b0;
                if (m_out && imem.imem_resp_valid) begin
                    m_out = 1'b0;
                    if (m_live && !PCSrcE) begin
                        m_rdy   = 1'b1;
                        m_raddr = m_oaddr;
                        m_pc    = m_oaddr + 32'd4;
                    end
                end
                if (m_rdy && PCSrcE) m_rdy = 1'b0;
                if (m_rdy && !StallD) begin
                    m_rdy = 1'b0;
                    dlv   = !FlushD;
                end
                if (PCSrcE) begin
                    m_pc   = PCTargetE;
                    m_live = 1'b0;
                end
                if (acc_m) begin
                    m_out   = 1'b1;
                    m_live  = !PCSrcE;
                    m_oaddr = a0;
                end
                if (FlushD) m_bubble();
                else if (!StallD) begin
                    if (dlv) begin
                        m_instr = tag(m_raddr);
                        m_pcd   = m_raddr;
                        m_pc4   = m_raddr + 32'd4;
                        m_valid = 1'b1;
                    end else m_bubble();
                end
                if (dlv) m_fetch = m_fetch + 32'd1;
            end
            // memory side
            if (reset) rem = 0;
            else begin
                if (acc_d) chk("single_outstanding", 32'(rem), 32'h0);
                if (rem != 0) rem--;
                if (acc_d) begin
                    rem   = mem_lat;
                    maddr = imem.imem_req_addr;
                end
            end
            #1;
            imem.imem_resp_valid = (rem == 1) || stray;
            imem.imem_resp_data  = stray ? 32'hDEAD_BEEF : tag(maddr);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic exp_rv;
        exp_rv = !reset && !m_out && !m_rdy && !StallF;
        chk("req_valid", 32'(imem.imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem.imem_req_addr, m_pc);
        chk("ValidD", 32'(ValidD), 32'(m_valid));
        chk("InstrD", InstrD, m_instr);
        chk("PCD", PCD, m_pcd);
        chk("PCPlus4D", PCPlus4D, m_pc4);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_stall", perf_stall_cnt, m_stall);
`endif
    end

    // Directed stimulus with literal expectations
    logic        vtab [1:6];
    logic [31:0] ptab [1:6];

    initial begin
        vtab = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ptab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0};
        reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'h0;
        imem.imem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_req_valid", 32'(imem.imem_req_valid), 32'h0);
        chk("rst_ValidD", 32'(ValidD), 32'h0);
        chk("rst_InstrD", InstrD, 32'h13);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        @(posedge clk);
        #2;
        for (int k = 1; k <= 42; k++) begin
            reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
            PCSrcE = 1'b0; stray = 1'b0;
            imem.imem_req_ready = 1'b1;
            case (k)
                6:  begin PCSrcE = 1'b1; PCTargetE = 32'h100; end
                9, 10, 11: StallD = 1'b1;
                14: FlushD = 1'b1;
                15, 17: imem.imem_req_ready = 1'b0;
                16, 18: begin imem.imem_req_ready = 1'b0; StallF = 1'b1; end
                21: begin PCSrcE = 1'b1; PCTargetE = 32'h200; mem_lat = 3; end
                22: begin PCSrcE = 1'b1; PCTargetE = 32'h302; end
                29: mem_lat = 1;
                31: begin
                    imem.imem_req_ready = 1'b0;
                    PCSrcE = 1'b1;
                    PCTargetE = 32'hFFFF_FFFC;
                end
                37: reset = 1'b1;
                38: begin reset = 1'b1; stray = 1'b1; end
                39: imem.imem_req_ready = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            if (k <= 6) begin
                chk("run_ValidD", 32'(ValidD), 32'(vtab[k]));
                chk("run_PCD", PCD, ptab[k]);
            end
            case (k)
                1: chk("first_addr", imem.imem_req_addr, 32'h0);
                3: chk("c3_addr", imem.imem_req_addr, 32'h4);
                6: begin
                    chk("acc0_cy", 32'(acc_cy[0]), 32'd1);
                    chk("acc1_cy", 32'(acc_cy[1]), 32'd3);
                    chk("acc2_cy", 32'(acc_cy[2]), 32'd5);
                    chk("acc2_ad", acc_ad[2], 32'h8);
                end
                7: begin
                    chk("redir_addr", imem.imem_req_addr, 32'h100);
                    chk("redir_drop", 32'(ValidD), 32'h0);
                end
                10, 11, 12: begin
                    chk("stall_hold_pc", PCD, 32'h100);
                    chk("stall_hold_v", 32'(ValidD), 32'h1);
                end
                13: begin
                    chk("unstall_pc", PCD, 32'h104);
                    chk("unstall_instr", InstrD, 32'hA5A5_0104);
                    chk("unstall_next", imem.imem_req_addr, 32'h108);
                end
                14: begin
                    chk("once_ValidD", 32'(ValidD), 32'h0);
`ifdef FETCH_PERF_EN
                    chk("perf_fetch_lit", perf_fetch_cnt, 32'd4);
                    chk("perf_stall_lit", perf_stall_cnt, 32'd7);
`endif
                end
                15: begin
                    chk("flush_instr", InstrD, 32'h13);
                    chk("flush_addr", imem.imem_req_addr, 32'h10C);
                end
                16, 18: chk("stallf_valid", 32'(imem.imem_req_valid), 32'h0);
                17: chk("stallf_valid", 32'(imem.imem_req_valid), 32'h1);
                24: chk("one_accept_10c", 32'(n_10c), 32'd1);
                23: chk("discard_noreq", 32'(imem.imem_req_valid), 32'h0);
                25: chk("discard_addr", imem.imem_req_addr, 32'h302);
                29: begin
                    chk("mis_pc", PCD, 32'h302);
                    chk("mis_pc4", PCPlus4D, 32'h306);
                end
                32: chk("wrap_addr", imem.imem_req_addr, 32'hFFFF_FFFC);
                34: begin
                    chk("wrap_pc4", PCPlus4D, 32'h0);
                    chk("wrap_next", imem.imem_req_addr, 32'h0);
                end
                36: chk("wrap_pcd4", PCPlus4D, 32'h4);
                38: chk("rst2_valid", 32'(ValidD), 32'h0);
                39: chk("rst2_addr", imem.imem_req_addr, 32'h0);
                42: chk("rst2_instr", InstrD, 32'hA5A5_0000);
                default: ;
            endcase
            @(posedge clk);
            #2;
        end
        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
